// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding request to a byte-addressed, big-endian
// 64-bit data memory. Loads are zero/sign extended; sub-double stores are
// done as read-modify-write of the 8-byte window at the request address.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned DATA_W    = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  input  logic              ReqWrite,
  input  logic [1:0]        ReqSize,
  input  logic              ReqSigned,
  input  logic [ADDR_W-1:0] ReqAddress,
  input  logic [DATA_W-1:0] ReqData,
  output logic              Ready,
  output logic              Done,
  output logic              Error,
  output logic [DATA_W-1:0] LoadData,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemReadData
);

  // Highest start address whose 8-byte window still fits in memory.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - 8);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDWAIT,
    S_WR,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   load_q, load_d;
  logic [DATA_W-1:0]   wbuf_q, wbuf_d;

  logic [DATA_W-1:0]   ext_data;
  logic [DATA_W-1:0]   merge_data;

  // Extract the top (lowest-address) field of the read window and extend it.
  always_comb begin
    unique case (size_q)
      2'd0:    ext_data = {{56{signed_q & MemReadData[63]}}, MemReadData[63:56]};
      2'd1:    ext_data = {{48{signed_q & MemReadData[63]}}, MemReadData[63:48]};
      2'd2:    ext_data = {{32{signed_q & MemReadData[63]}}, MemReadData[63:32]};
      default: ext_data = MemReadData;
    endcase
  end

  // Replace the top field of the read window with the store data's low field.
  always_comb begin
    unique case (size_q)
      2'd0:    merge_data = {data_q[7:0],  MemReadData[55:0]};
      2'd1:    merge_data = {data_q[15:0], MemReadData[47:0]};
      2'd2:    merge_data = {data_q[31:0], MemReadData[31:0]};
      default: merge_data = data_q;
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;
    load_d   = load_q;
    wbuf_d   = wbuf_q;

    unique case (state_q)
      S_IDLE: begin
        if (ReqValid) begin
          write_d  = ReqWrite;
          size_d   = ReqSize;
          signed_d = ReqSigned;
          addr_d   = ReqAddress;
          data_d   = ReqData;
          if (ReqAddress > LAST_ADDR) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d = 1'b0;
            if (ReqWrite && ReqSize == 2'd3) begin
              wbuf_d  = ReqData;
              state_d = S_WR;
            end else begin
              state_d = S_RD;
            end
          end
        end
      end
      S_RD:     state_d = S_RDWAIT;
      S_RDWAIT: begin
        if (write_q) begin
          wbuf_d  = merge_data;
          state_d = S_WR;
        end else begin
          load_d  = ext_data;
          state_d = S_DONE;
        end
      end
      S_WR:     state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and request registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      load_q   <= '0;
      wbuf_q   <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
      load_q   <= load_d;
      wbuf_q   <= wbuf_d;
    end
  end

  assign Ready        = (state_q == S_IDLE);
  assign Done         = (state_q == S_DONE);
  assign Error        = (state_q == S_DONE) && err_q;
  assign MemRead      = (state_q == S_RD);
  assign MemWrite     = (state_q == S_WR);
  assign MemAddress   = addr_q;
  assign MemWriteData = wbuf_q;
  assign LoadData     = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory model on the memory port,
// table of directed requests, hand sequences for busy/reset corner cases,
// and random requests checked against a byte-level reference memory.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid, ReqWrite, ReqSigned;
  logic [1:0]  ReqSize;
  logic [63:0] ReqAddress, ReqData;
  logic        Ready, Done, Error, MemRead, MemWrite;
  logic [63:0] LoadData, MemAddress, MemWriteData, MemReadData;

  load_store_unit #(.MEM_BYTES(1024), .ADDR_W(64), .DATA_W(64)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
    .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddress(ReqAddress),
    .ReqData(ReqData), .Ready(Ready), .Done(Done), .Error(Error),
    .LoadData(LoadData), .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemReadData(MemReadData)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory attached to the port: registers read data on the MemRead edge.
  logic [7:0] mem [0:1023];
  always @(posedge Clk) begin
    if (MemRead) begin
      for (int i = 0; i < 8; i++) begin
        int idx;
        idx = int'(MemAddress[9:0]) + i;
        MemReadData[63-8*i -: 8] <= (idx < 1024) ? mem[idx] : 8'h00;
      end
    end
    if (MemWrite) begin
      for (int i = 0; i < 8; i++) begin
        int idx;
        idx = int'(MemAddress[9:0]) + i;
        if (idx < 1024) mem[idx] = MemWriteData[63-8*i -: 8];
      end
    end
  end

  // Reference model: plain byte array updated per request.
  logic [7:0]  ref_mem [0:1023];
  logic [63:0] exp_ld;
  logic [63:0] cur_addr;
  logic [63:0] exp_wdata;
  int rd_cnt, wr_cnt, done_cnt;

  function automatic logic [63:0] ref_load(input int a, input logic [1:0] sz, input logic sg);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[a+i]);
    if (sg && n < 8 && v[8*n-1]) v = v | (~64'h0 << (8*n));
    return v;
  endfunction

  function automatic logic [63:0] ref_window(input int a);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v = (v << 8) | 64'(ref_mem[a+i]);
    return v;
  endfunction

  task automatic ref_store(input int a, input logic [1:0] sz, input logic [63:0] d);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) ref_mem[a+i] = 8'(d >> (8*(n-1-i)));
  endtask

  // Bus monitor, sampled on the falling edge.
  always @(negedge Clk) begin
    if (MemRead)  rd_cnt++;
    if (MemWrite) wr_cnt++;
    if (Done)     done_cnt++;
    if (MemRead && MemWrite) chk("rd_wr_overlap", 64'(MemRead & MemWrite), 64'd0);
    if (MemRead || MemWrite) chk("mem_address", MemAddress, cur_addr);
    if (MemWrite) chk("mem_write_data", MemWriteData, exp_wdata);
  end

  // Issue one request from IDLE (called #1 after an edge) and check completion.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] d,
                        input logic [63:0] e_ld, input logic e_err, input int e_lat);
    int lat;
    bit seen;
    int e_rd, e_wr;
    for (int k = 0; k < 20 && !Ready; k++) begin
      @(posedge Clk); #1;
    end
    chk("ready_before_req", 64'(Ready), 64'd1);
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    cur_addr = a;
    ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sg;
    ReqAddress = a; ReqData = d;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    lat = 0; seen = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      if (Done) begin
        seen = 1;
        lat = k;
        chk("error", 64'(Error), 64'(e_err));
        chk("load_data", LoadData, e_ld);
      end else begin
        @(posedge Clk); #1;
      end
    end
    chk("latency", 64'(lat), 64'(e_lat));
    @(posedge Clk); #1;
    e_rd = (!e_err && (!wr || sz != 2'd3)) ? 1 : 0;
    e_wr = (!e_err && wr) ? 1 : 0;
    chk("read_count", 64'(rd_cnt), 64'(e_rd));
    chk("write_count", 64'(wr_cnt), 64'(e_wr));
    chk("done_count", 64'(done_cnt), 64'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] e_ld;
    logic        e_err;
    int          e_lat;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [7:0] pre [8];
    pre = '{8'hF1, 8'hE2, 8'hD3, 8'hC4, 8'hB5, 8'hA6, 8'h97, 8'h88};
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 8; i++) begin
      mem[i] = pre[i];
      ref_mem[i] = pre[i];
    end

    tbl[0] = '{1'b0, 2'd0, 1'b1, 64'd0,    64'd0,                  64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 3};
    tbl[1] = '{1'b0, 2'd1, 1'b0, 64'd2,    64'd0,                  64'h0000_0000_0000_D3C4, 1'b0, 3};
    tbl[2] = '{1'b0, 2'd2, 1'b1, 64'd4,    64'd0,                  64'hFFFF_FFFF_B5A6_9788, 1'b0, 3};
    tbl[3] = '{1'b0, 2'd0, 1'b0, 64'd0,    64'd0,                  64'h0000_0000_0000_00F1, 1'b0, 3};
    tbl[4] = '{1'b1, 2'd0, 1'b0, 64'd3,    64'hFFFF_FFFF_FFFF_FF5A, 64'h0000_0000_0000_00F1, 1'b0, 4};
    tbl[5] = '{1'b0, 2'd3, 1'b0, 64'd0,    64'd0,                  64'hF1E2_D35A_B5A6_9788, 1'b0, 3};
    tbl[6] = '{1'b1, 2'd3, 1'b0, 64'd1016, 64'h0123_4567_89AB_CDEF, 64'hF1E2_D35A_B5A6_9788, 1'b0, 2};
    tbl[7] = '{1'b0, 2'd3, 1'b1, 64'd1016, 64'd0,                  64'h0123_4567_89AB_CDEF, 1'b0, 3};
    tbl[8] = '{1'b0, 2'd0, 1'b1, 64'd1017, 64'd0,                  64'h0123_4567_89AB_CDEF, 1'b1, 1};
    tbl[9] = '{1'b1, 2'd3, 1'b0, 64'd1017, 64'h5555_AAAA_5555_AAAA, 64'h0123_4567_89AB_CDEF, 1'b1, 1};

    Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = '0; ReqSigned = 1'b0;
    ReqAddress = '0; ReqData = '0; cur_addr = '0; exp_wdata = '0; exp_ld = '0;
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;

    // Reset state
    #12;
    chk("rst_ready", 64'(Ready), 64'd1);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_error", 64'(Error), 64'd0);
    chk("rst_memrd", 64'(MemRead), 64'd0);
    chk("rst_memwr", 64'(MemWrite), 64'd0);
    chk("rst_loaddata", LoadData, 64'd0);
    chk("rst_memaddr", MemAddress, 64'd0);
    chk("rst_memwdata", MemWriteData, 64'd0);
    @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr && !tbl[i].e_err) begin
        ref_store(int'(tbl[i].addr), tbl[i].sz, tbl[i].data);
        exp_wdata = ref_window(int'(tbl[i].addr));
      end
      do_req(tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].addr, tbl[i].data,
             tbl[i].e_ld, tbl[i].e_err, tbl[i].e_lat);
    end
    exp_ld = 64'h0123_4567_89AB_CDEF;

    // ReqValid held high through a busy load: second request only after IDLE
    rd_cnt = 0; done_cnt = 0; cur_addr = '0;
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'd3; ReqSigned = 1'b0;
    ReqAddress = '0; ReqData = '0;
    @(posedge Clk); #1;
    for (int k = 1; k <= 3; k++) begin
      chk("busy_ready", 64'(Ready), 64'd0);
      if (k < 3) begin
        @(posedge Clk); #1;
      end
    end
    chk("busy_done1", 64'(Done), 64'd1);
    @(posedge Clk); #1;
    chk("busy_idle_ready", 64'(Ready), 64'd1);
    @(posedge Clk); #1;
    chk("busy_second_accept", 64'(Ready), 64'd0);
    ReqValid = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    exp_ld = ref_load(0, 2'd3, 1'b0);
    chk("busy_done2", 64'(Done), 64'd1);
    chk("busy_load", LoadData, exp_ld);
    @(posedge Clk); #1;
    chk("busy_reads", 64'(rd_cnt), 64'd2);
    chk("busy_dones", 64'(done_cnt), 64'd2);

    // Reset during RDWAIT of a byte store: nothing is written
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; cur_addr = '0;
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd0; ReqAddress = '0; ReqData = 64'h77;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    #1;
    chk("abort_ready", 64'(Ready), 64'd1);
    chk("abort_done", 64'(Done), 64'd0);
    chk("abort_memrd", 64'(MemRead), 64'd0);
    chk("abort_memwr", 64'(MemWrite), 64'd0);
    chk("abort_loaddata", LoadData, 64'd0);
    chk("abort_memaddr", MemAddress, 64'd0);
    chk("abort_memwdata", MemWriteData, 64'd0);
    exp_ld = '0;
    @(posedge Clk); @(negedge Clk); Reset = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    chk("abort_mem0", 64'(mem[0]), 64'hF1);
    chk("abort_writes", 64'(wr_cnt), 64'd0);
    chk("abort_dones", 64'(done_cnt), 64'd0);

    // Reset during DONE of a byte store: the write stands
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; cur_addr = '0;
    ref_store(0, 2'd0, 64'h66);
    exp_wdata = ref_window(0);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd0; ReqAddress = '0; ReqData = 64'h66;
    @(posedge Clk); #1;
    ReqValid = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("late_rst_in_done", 64'(Done), 64'd1);
    Reset = 1'b1;
    #1;
    chk("late_rst_done_clear", 64'(Done), 64'd0);
    @(posedge Clk); @(negedge Clk); Reset = 1'b0;
    @(posedge Clk); #1;
    chk("late_rst_mem0", 64'(mem[0]), 64'h66);
    chk("late_rst_writes", 64'(wr_cnt), 64'd1);
    chk("late_rst_dones", 64'(done_cnt), 64'd0);

    // Random requests against the reference memory
    for (int t = 0; t < 300; t++) begin
      logic        wr, sg, err;
      logic [1:0]  sz;
      logic [63:0] a, d, e;
      int          lat;
      wr = 1'($urandom);
      sg = 1'($urandom);
      sz = 2'($urandom);
      d  = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0:       a = 64'(1017 + $urandom_range(0, 20));
        1:       a = {1'b1, 31'($urandom), $urandom};
        2:       a = 64'(1016 - $urandom_range(0, 7));
        default: a = 64'($urandom_range(0, 1016));
      endcase
      err = (a > 64'd1016);
      if (err) lat = 1;
      else if (!wr) lat = 3;
      else if (sz == 2'd3) lat = 2;
      else lat = 4;
      if (!err && !wr) exp_ld = ref_load(int'(a), sz, sg);
      if (!err && wr) begin
        ref_store(int'(a), sz, d);
        exp_wdata = ref_window(int'(a));
      end
      e = exp_ld;
      do_req(wr, sz, sg, a, d, e, err, lat);
    end

    // Final memory image against the reference
    for (int i = 0; i < 1024; i += 8)
      chk("final_mem", {mem[i], mem[i+1], mem[i+2], mem[i+3], mem[i+4], mem[i+5], mem[i+6], mem[i+7]},
          ref_window(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
